// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the regfile_sb register file: load funct3 codes,
// the a0 register index and the ecall FSM state encoding.
package regfile_sb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int A0_IDX = 10;

  typedef enum logic {
    ECALL_IDLE = 1'b0,
    ECALL_WAIT = 1'b1
  } ecall_state_t;

endpackage

// File: rtl/regfile_sb_load_ext.sv
// Load-data extension: sign/zero extends byte and half loads, passes
// every other funct3 through unchanged.
module load_ext
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = data;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){data[7]}}, data[7:0]};
      F3_LH:   ext = {{(XLEN-16){data[15]}}, data[15:0]};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, data[7:0]};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and an ecall input FSM for a0.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RPORTS = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stop,
  input  logic [RPORTS*AW-1:0]   rd_addr,
  output logic [RPORTS*XLEN-1:0] rd_data,
  output logic [RPORTS-1:0]      hazard,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [2:0]             wb_funct3,
  input  logic                   wb_load,
  input  logic                   ecall_req,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_data,
  output logic                   in_ready,
  output logic                   ecall_busy,
  output ecall_state_t           ecall_state,
  output logic [XLEN-1:0]        dbg_last,
  output logic [XLEN-1:0]        dbg_prev
);

  localparam logic [AW-1:0] A0 = AW'(A0_IDX);

  // Handshake: in_ready is high in WAIT while not stopped; a beat is accepted
  // on any rising edge where in_valid && in_ready, with no other qualifier.

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  ecall_state_t    state;

  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] wb_val;
  logic            accept;
  logic            ecall_start;
  logic            wb_fire;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .data   (wb_data),
    .funct3 (wb_funct3),
    .ext    (ext_data)
  );

  assign wb_val      = wb_load ? ext_data : wb_data;
  assign accept      = (state == ECALL_WAIT) && in_valid && !stop;
  assign ecall_start = (state == ECALL_IDLE) && ecall_req && !stop;
  // The external input owns a0 in the accept cycle; a racing writeback loses.
  assign wb_fire     = wb_en && (wb_rd != '0) && !(accept && (wb_rd == A0)) && !stop;

  assign in_ready    = (state == ECALL_WAIT) && !stop;
  assign ecall_busy  = (state == ECALL_WAIT);
  assign ecall_state = state;
  assign dbg_last    = regs[NREG-1];
  assign dbg_prev    = regs[NREG-2];

  // Clears are applied before sets so an issue in the same cycle wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_en)       pending_nxt[wb_rd]  = 1'b0;
    if (accept)      pending_nxt[A0]     = 1'b0;
    if (iss_en)      pending_nxt[iss_rd] = 1'b1;
    if (ecall_start) pending_nxt[A0]     = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      pending <= '0;
    end else if (!stop) begin
      if (wb_fire) regs[wb_rd] <= wb_val;
      if (accept)  regs[A0]    <= in_data;
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ECALL_IDLE;
    end else if (!stop) begin
      case (state)
        ECALL_IDLE: if (ecall_req) state <= ECALL_WAIT;
        ECALL_WAIT: if (in_valid)  state <= ECALL_IDLE;
        default:                   state <= ECALL_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < RPORTS; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            haz;

    assign ra = rd_addr[p*AW +: AW];

    always_comb begin
      rdat = regs[ra];
      haz  = pending[ra];
`ifdef REGFILE_BYPASS_EN
      if (reset && (ra != '0)) begin
        if (accept && (ra == A0)) begin
          rdat = in_data;
          haz  = 1'b0;
        end else if (wb_fire && (wb_rd == ra)) begin
          rdat = wb_val;
          haz  = 1'b0;
        end
      end
`endif
    end

    assign rd_data[p*XLEN +: XLEN] = rdat;
    assign hazard[p]               = haz;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a spec-level model checked on every negedge
// plus literal expectations for each scenario.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int XLEN = 32, NREG = 32, RPORTS = 2, AW = 5;

  logic                   clk, reset, stop;
  logic [RPORTS*AW-1:0]   rd_addr;
  logic [RPORTS*XLEN-1:0] rd_data;
  logic [RPORTS-1:0]      hazard;
  logic                   iss_en, wb_en, wb_load, ecall_req, in_valid;
  logic [AW-1:0]          iss_rd, wb_rd;
  logic [XLEN-1:0]        wb_data, in_data, dbg_last, dbg_prev;
  logic [2:0]             wb_funct3;
  logic                   in_ready, ecall_busy;
  ecall_state_t           ecall_state;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .RPORTS(RPORTS)) dut (
    .clk(clk), .reset(reset), .stop(stop), .rd_addr(rd_addr), .rd_data(rd_data),
    .hazard(hazard), .iss_en(iss_en), .iss_rd(iss_rd), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_funct3(wb_funct3), .wb_load(wb_load), .ecall_req(ecall_req),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .ecall_busy(ecall_busy),
    .ecall_state(ecall_state), .dbg_last(dbg_last), .dbg_prev(dbg_prev)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_rd(input int p, input logic [XLEN-1:0] v);
    exp_q.push_back(v);
    chk($sformatf("lit_rd%0d", p), rd_data[p*XLEN +: XLEN], exp_q.pop_front());
  endtask

  // model: extension by arithmetic on the value, not by bit replication
  function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [2:0] f, input logic ld);
    longint v;
    v = longint'(d);
    if (ld) begin
      case (f)
        3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
        3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
        3'b100: v = v % 256;
        3'b101: v = v % 65536;
        default: v = longint'(d);
      endcase
    end
    return v[31:0];
  endfunction

  logic [31:0] m_regs [NREG];
  bit          m_pend [NREG];
  bit          m_wait;

  always @(posedge clk or negedge reset) begin
    bit acc, st;
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
      m_wait = 0;
    end else if (!stop) begin
      acc = m_wait && in_valid;
      st  = !m_wait && ecall_req;
      if (wb_en && wb_rd != 0 && !(acc && wb_rd == 10)) m_regs[wb_rd] = m_ext(wb_data, wb_funct3, wb_load);
      if (acc) m_regs[10] = in_data;
      if (wb_en) m_pend[wb_rd] = 0;
      if (acc) m_pend[10] = 0;
      if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1;
      if (st) m_pend[10] = 1;
      if (st) m_wait = 1;
      else if (acc) m_wait = 0;
    end
  end

  // compare process
  always @(negedge clk) begin
    for (int p = 0; p < RPORTS; p++) begin
      logic [AW-1:0] ra;
      logic [31:0]   ed;
      logic          eh;
      ra = rd_addr[p*AW +: AW];
      ed = m_regs[ra];
      eh = m_pend[ra];
`ifdef REGFILE_BYPASS_EN
      if (reset && !stop && ra != 0) begin
        if (m_wait && in_valid && ra == 10) begin ed = in_data; eh = 0; end
        else if (wb_en && wb_rd == ra) begin ed = m_ext(wb_data, wb_funct3, wb_load); eh = 0; end
      end
`endif
      chk($sformatf("rd_data%0d", p), rd_data[p*XLEN +: XLEN], ed);
      chk($sformatf("hazard%0d", p), hazard[p], eh);
    end
    chk("in_ready", in_ready, m_wait && !stop && reset);
    chk("ecall_busy", ecall_busy, m_wait);
    chk("ecall_state", ecall_state, m_wait);
    chk("dbg_last", dbg_last, m_regs[NREG-1]);
    chk("dbg_prev", dbg_prev, m_regs[NREG-2]);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    wb_en = 0; iss_en = 0; ecall_req = 0; in_valid = 0;
  endtask

  task automatic wb(input logic [AW-1:0] rd, input logic [31:0] d, input logic [2:0] f, input logic ld);
    wb_en = 1; wb_rd = rd; wb_data = d; wb_funct3 = f; wb_load = ld;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  logic [AW-1:0] t_rd  [8] = '{5, 5, 6, 6, 6, 8, 30, 31};
  logic [31:0]   t_dat [8] = '{32'hF0, 32'hF0, 32'h8000, 32'h8000, 32'h87654321, 32'h80, 32'h12345678, 32'hDEADBEEF};
  logic [2:0]    t_f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000, 3'b000};
  logic          t_ld  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  logic [31:0]   t_exp [8] = '{32'hFFFFFFF0, 32'hF0, 32'hFFFF8000, 32'h8000, 32'h87654321, 32'h80, 32'h12345678, 32'hDEADBEEF};

  initial begin
    int busy_cnt;
    reset = 0; stop = 0; rd_addr = '0; in_data = '0;
    iss_rd = '0; wb_rd = '0; wb_data = '0; wb_funct3 = '0; wb_load = 0;
    idle_inputs();

    // activity during reset must not leak out
    wb(5, 32'hFF, 3'b000, 0); iss_en = 1; iss_rd = 5; ecall_req = 1; set_rd(5, 10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rd(0, 32'h0);
    chk("rst_hazard", hazard, 2'b00);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", ecall_busy, 1'b0);
    @(posedge clk); #1;
    idle_inputs(); reset = 1;

    // load extension and plain writes
    for (int i = 0; i < 8; i++) begin
      set_rd(t_rd[i], 0);
      wb(t_rd[i], t_dat[i], t_f3[i], t_ld[i]);
      tick(); idle_inputs();
      @(negedge clk);
      check_rd(0, t_exp[i]);
    end
    chk("lit_dbg_last", dbg_last, 32'hDEADBEEF);
    chk("lit_dbg_prev", dbg_prev, 32'h12345678);

    // x0 is hardwired
    tick();
    set_rd(0, 0); wb(0, 32'h1234, 3'b000, 0); iss_en = 1; iss_rd = 0;
    tick(); idle_inputs();
    @(negedge clk);
    check_rd(0, 32'h0);
    chk("lit_x0_hazard", hazard[0], 1'b0);

    // hazard on x7 and write-through behaviour
    tick();
    set_rd(7, 0); iss_en = 1; iss_rd = 7;
    tick(); idle_inputs();
    @(negedge clk);
    chk("lit_x7_pending", hazard[0], 1'b1);
    tick();
    wb(7, 32'h55, 3'b000, 0);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check_rd(0, 32'h55);
    chk("lit_x7_wb_hazard", hazard[0], 1'b0);
`else
    check_rd(0, 32'h0);
    chk("lit_x7_wb_hazard", hazard[0], 1'b1);
`endif
    tick(); idle_inputs();
    @(negedge clk);
    check_rd(0, 32'h55);
    chk("lit_x7_after_hazard", hazard[0], 1'b0);

    // same-cycle issue and writeback: issue wins
    tick();
    set_rd(3, 0); iss_en = 1; iss_rd = 3; wb(3, 32'h33, 3'b000, 0);
    tick(); idle_inputs();
    @(negedge clk);
    chk("lit_x3_pending", hazard[0], 1'b1);
    check_rd(0, 32'h33);
    tick();
    wb(3, 32'h33, 3'b000, 0);
    tick(); idle_inputs();
    @(negedge clk);
    chk("lit_x3_cleared", hazard[0], 1'b0);

    // ecall with long wait, ignored re-request, racing wb to x10
    tick();
    set_rd(10, 12); ecall_req = 1;
    tick(); ecall_req = 0;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      ecall_req = (i == 2);
      @(negedge clk);
      if (ecall_busy) busy_cnt++;
      if (i == 0) chk("lit_a0_pending", hazard[0], 1'b1);
      tick();
    end
    ecall_req = 0; in_valid = 1; in_data = 32'hABCD; wb(10, 32'h1, 3'b000, 0);
    @(negedge clk);
    if (ecall_busy) busy_cnt++;
    chk("lit_in_ready", in_ready, 1'b1);
    tick(); idle_inputs();
    @(negedge clk);
    chk("lit_busy_cycles", busy_cnt, 6);
    chk("lit_busy_done", ecall_busy, 1'b0);
    check_rd(0, 32'hABCD);
    chk("lit_a0_cleared", hazard[0], 1'b0);

    // accept alongside a writeback to another register
    tick();
    ecall_req = 1;
    tick(); idle_inputs();
    in_valid = 1; in_data = 32'h2222; wb(12, 32'h77, 3'b000, 0);
    tick(); idle_inputs();
    @(negedge clk);
    check_rd(0, 32'h2222);
    check_rd(1, 32'h77);

    // stop freezes everything
    tick();
    set_rd(20, 21); wb(20, 32'hA5, 3'b000, 0);
    tick(); idle_inputs();
    stop = 1; wb(20, 32'h99, 3'b000, 0); iss_en = 1; iss_rd = 21; ecall_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_stop_busy", ecall_busy, 1'b0);
      tick();
    end
    stop = 0; idle_inputs();
    @(negedge clk);
    check_rd(0, 32'hA5);
    chk("lit_stop_no_issue", hazard[1], 1'b0);

    // stop during WAIT holds off the accept
    tick();
    set_rd(10, 0); ecall_req = 1;
    tick(); idle_inputs();
    stop = 1; in_valid = 1; in_data = 32'h3333;
    @(negedge clk);
    chk("lit_stop_in_ready", in_ready, 1'b0);
    tick(); tick();
    stop = 0;
    @(negedge clk);
    chk("lit_resume_in_ready", in_ready, 1'b1);
    tick(); idle_inputs();
    @(negedge clk);
    chk("lit_resume_busy", ecall_busy, 1'b0);
    check_rd(0, 32'h3333);

    // reset mid-WAIT abandons the ecall
    tick();
    ecall_req = 1;
    tick(); idle_inputs();
    @(negedge clk);
    chk("lit_wait_busy", ecall_busy, 1'b1);
    #2 reset = 0; in_valid = 1; in_data = 32'h7777;
    #1;
    chk("lit_rst_busy", ecall_busy, 1'b0);
    chk("lit_rst_state", ecall_state, ECALL_IDLE);
    check_rd(0, 32'h0);
    tick();
    reset = 1; in_valid = 0;
    tick();
    @(negedge clk);
    check_rd(0, 32'h0);
    chk("lit_post_rst_state", ecall_state, ECALL_IDLE);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
